// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MERGE   = 3'd3,
    ST_WRITE   = 3'd4
  } lsu_state_e;

  // Alignment, funct3 and range check; computed in 33 bits so the top of
  // the address space cannot wrap into range.
  function automatic logic req_legal(input logic        we,
                                     input logic [2:0]  funct3,
                                     input logic [31:0] addr,
                                     input logic [32:0] mem_bytes);
    logic [32:0] last_s;
    logic        ok_s;
    last_s = {1'b0, addr[31:2], 2'b00} + 33'd3;
    case (funct3)
      F3_B:    ok_s = 1'b1;
      F3_H:    ok_s = ~addr[0];
      F3_W:    ok_s = (addr[1:0] == 2'b00);
      F3_BU:   ok_s = ~we;
      F3_HU:   ok_s = ~we & ~addr[0];
      default: ok_s = 1'b0;
    endcase
    return ok_s && (last_s < mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the execute stage (master) and the
// load/store unit (slave).
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering shared by load capture (extract + extend) and
// sub-word store merge.
module lsu_align import lsu_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  shamt_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, extension and merge
  always_comb begin
    shamt_s = {offset, 3'b000};
    byte_s  = word[shamt_s +: 8];
    half_s  = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_val = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_val = {{16{half_s[15]}}, half_s};
      F3_W:    load_val = word;
      F3_BU:   load_val = {24'd0, byte_s};
      F3_HU:   load_val = {16'd0, half_s};
      default: load_val = 32'd0;
    endcase
    merged = word;
    case (funct3)
      F3_B:    merged[shamt_s +: 8] = sdata[7:0];
      F3_H:    merged[{offset[1], 4'b0000} +: 16] = sdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide RAM port with 1-cycle read
// latency; sub-word stores are done as read-modify-write.
module load_store_unit import lsu_pkg::*; #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  lsu_if.slave        bus,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  lsu_state_e  state_r, state_next_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merged_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        legal_s;
  logic        is_sw_s;
  logic [31:0] aligned_s;
  logic [31:0] load_val_s;
  logic [31:0] merged_s;

  assign legal_s   = req_legal(bus.req_we, bus.req_funct3, bus.req_addr, MEM_LIMIT);
  assign is_sw_s   = we_r && (funct3_r == F3_W);
  assign aligned_s = {addr_r[31:2], 2'b00};

  assign bus.req_ready  = (state_r == ST_IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

  lsu_align u_align (
    .word     (mem_rdata),
    .offset   (addr_r[1:0]),
    .funct3   (funct3_r),
    .sdata    (wdata_r[15:0]),
    .load_val (load_val_s),
    .merged   (merged_s)
  );

  // State register, request latches and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      merged_r     <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            if (!legal_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end
          end
        end
        ST_ISSUE: begin
          if (is_sw_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
          end
        end
        ST_CAPTURE: begin
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= load_val_s;
        end
        ST_MERGE: merged_r <= merged_s;
        ST_WRITE: begin
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid && legal_s) state_next_s = ST_ISSUE;
        else                          state_next_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (is_sw_s)   state_next_s = ST_IDLE;
        else if (we_r) state_next_s = ST_MERGE;
        else           state_next_s = ST_CAPTURE;
      end
      ST_CAPTURE: state_next_s = ST_IDLE;
      ST_MERGE:   state_next_s = ST_WRITE;
      ST_WRITE:   state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // RAM port drive; rst gates en/wr so an abandoned write never lands
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (state_r)
      ST_ISSUE: begin
        mem_en    = ~rst;
        mem_wr    = ~rst & is_sw_s;
        mem_addr  = aligned_s;
        mem_wdata = is_sw_s ? wdata_r : 32'd0;
      end
      ST_WRITE: begin
        mem_en    = ~rst;
        mem_wr    = ~rst;
        mem_addr  = aligned_s;
        mem_wdata = merged_r;
      end
      default: mem_en = 1'b0;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side client of the dual-port RAM's data port (en/wr/addr/wdata in, registered data out, 1-cycle read latency, word-only writes).
- Accepts RV32I load/store requests from the execute stage.
- Performs byte-lane extraction and sign/zero extension for loads.
- Performs sub-word stores (SB/SH) as read-modify-write, because the RAM writes all 4 bytes on every write.

Parameters:
- MEM_BYTES, 4096, RAM size in bytes; a request with aligned address + 3 >= MEM_BYTES is an access error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned, illegal funct3 or out of range
- mem_en  out  1  RAM data-port enable
- mem_wr  out  1  RAM write
- mem_addr  out  32  RAM byte address, always word-aligned (req_addr & ~3)
- mem_wdata  out  32  RAM write word
- mem_rdata  in  32  RAM registered read word, valid the cycle after an en=1, wr=0 access

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, internal request latches 0.
- Memory outputs are combinational from state. mem_en, mem_wr, mem_addr and mem_wdata are 0 outside ISSUE/WRITE, and mem_en and mem_wr are 0 in any cycle with rst=1.
- States: IDLE, ISSUE, CAPTURE, MERGE, WRITE.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Request illegal (misaligned LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, load funct3 in {3,6,7}, store funct3 >= 3, or out of range): stay in IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0. No RAM access occurs.
  - Otherwise go to ISSUE.
- ISSUE: mem_en=1, mem_addr=aligned.
  - SW: mem_wr=1, mem_wdata=req_wdata; next state IDLE; resp_valid next cycle.
  - Load or SB/SH: mem_wr=0.
  - Next state CAPTURE for loads, MERGE for SB/SH.
- CAPTURE: extract from mem_rdata by addr[1:0] into resp_rdata (registered).
  - LB/LBU: byte lane addr[1:0]; LH/LHU: half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Next state IDLE; resp_valid pulses the following cycle.
- MERGE: register merged word = mem_rdata with the addressed byte (SB) or half (SH) replaced by req_wdata[7:0] or req_wdata[15:0]. Next state WRITE.
- WRITE: mem_en=1, mem_wr=1, mem_wdata=merged word. Next state IDLE; resp_valid next cycle.
- Latency from accept cycle to resp_valid:
  - error: 1
  - SW: 2
  - load: 3
  - SB/SH: 4
- resp_valid coincides with IDLE, so back-to-back requests are accepted in the resp_valid cycle.
- Store results: resp_rdata=0, resp_err=0.
- The unit does not forward. A load following a store observes the written value, because the RAM write completes at the end of the WRITE/ISSUE cycle.
- Reset mid-operation: the operation is abandoned and no RAM write occurs in the reset cycle. A WRITE already completed is not undone. No resp_valid is produced for the abandoned request.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_e
  - function for the alignment/legality check
- One combinational sub-module, lsu_align: inputs word, offset, funct3, store data; outputs extracted load value and merged store word. It is shared by CAPTURE and MERGE.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF -> ISSUE cycle with mem_wr=1, mem_addr=0x10; resp_valid 2 cycles after accept, err=0. Then LW 0x10 -> resp_rdata=0xDEADBEEF 3 cycles after accept.
- With word 0x80FF7F01 at 0x20: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
- Word 0x11223344 at 0x30: SB 0x31 with data 0xAA -> word 0x1122AA44; SH 0x32 with data 0xBEEF -> 0xBEEFAA44. Check exactly one write per store and 4-cycle latency.
- LW 0x12, SH 0x33, LB funct3=3, SW 0x1000 (MEM_BYTES=4096) -> each gives resp_err=1 one cycle after accept, with mem_en never asserted. LW 0xFFC -> legal.
- Back-to-back: SW then LW to the same address with req_valid held high -> second request accepted in the first resp_valid cycle; load returns the stored value.
- Assert rst during the WRITE of an SB -> mem_wr=0 that cycle, RAM word unchanged, no resp_valid, req_ready=1 the cycle after reset deasserts.
